mips_multicycle_controller: RTL
===============================

// Module: mips_multicycle_controller
// PURPOSE
//  Moore/Mealy FSM that sequences a multi-cycle MIPS datapath: one shared memory, IR, ALU and register file reused over 3-5 states per instruction.
//  Decodes opcode from the IR and drives all datapath mux selects and write enables. Stalls on a memory ready handshake.
//  Halts on an illegal opcode or a memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  255  max consecutive wait cycles with mem_ready=0 before error; 0 = no timeout
//  CNT_W        32   width of performance counters
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      reset, asynchronous, active-low
//  opcode         in   6      IR[31:26]
//  mem_ready      in   1      memory completes read/write this cycle
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load if ALU zero (beq)
//  i_or_d         out  1      mem addr: 0=PC, 1=ALUOut
//  mem_read       out  1      memory read request
//  mem_write      out  1      memory write request
//  mem_to_reg     out  1      RF write data: 0=ALUOut, 1=MDR
//  ir_write       out  1      IR load
//  pc_source      out  2      00=ALU, 01=ALUOut, 10=jump addr
//  alu_op         out  2      00=add, 01=sub, 10=funct
//  alu_src_a      out  1      0=PC, 1=A reg
//  alu_src_b      out  2      00=B, 01=4, 10=signext, 11=signext<<2
//  reg_write      out  1      RF write enable
//  reg_dst        out  1      0=rt, 1=rd
//  instr_done     out  1      1-cycle pulse, instruction retires
//  halted         out  1      FSM in HALT
//  illegal_op     out  1      sticky: unsupported opcode decoded
//  mem_err        out  1      sticky: memory timeout
//  state_dbg      out  4      current state encoding
//  cycle_cnt      out  CNT_W  cycles since reset (feature)
//  instr_cnt      out  CNT_W  retired instructions (feature)
// BEHAVIOUR
//  - Reset: state=FETCH(0), wait counter=0, flags=0. While rst_n=0, every output is 0, including counters.
//  - Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000. All others are illegal.
//  - States / outputs (unlisted outputs are 0):
//    FETCH(0): mem_read, alu_src_b=01. ir_write and pc_write only when mem_ready. Next: DECODE on ready, else stay.
//    DECODE(1): alu_src_b=11. Next by opcode: lw/sw->MEMADR, R->EXEC, beq->BRANCH, j->JUMP, addi->ADDIEX, else HALT with illegal_op set.
//    MEMADR(2): alu_src_a, alu_src_b=10. Next: MEMRD (lw) or MEMWR (sw).
//    MEMRD(3): mem_read, i_or_d. Next: MEMWB on ready, else stay.
//    MEMWB(4): reg_write, mem_to_reg, instr_done. Next: FETCH.
//    MEMWR(5): mem_write, i_or_d. instr_done on ready. Next: FETCH on ready, else stay.
//    EXEC(6): alu_src_a, alu_op=10. Next: ALUWB.
//    ALUWB(7): reg_write, reg_dst, instr_done. Next: FETCH.
//    BRANCH(8): alu_src_a, alu_op=01, pc_write_cond, pc_source=01, instr_done. Next: FETCH.
//    JUMP(9): pc_write, pc_source=10, instr_done. Next: FETCH.
//    ADDIEX(10): alu_src_a, alu_src_b=10. Next: ADDIWB.
//    ADDIWB(11): reg_write, instr_done. Next: FETCH.
//    HALT(12): halted=1, all strobes 0. Exits only on reset.
//  - CPI: lw 5, sw 4, R/addi 4, beq/j 3, plus one cycle per wait cycle.
//  - Wait counter: clears on entering FETCH/MEMRD/MEMWR; increments each cycle the FSM is in one of them with mem_ready=0.
//    If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: next state=HALT, mem_err set.
//    mem_ready=1 in that same cycle wins, so no error is raised.
//  - mem_ready is ignored outside the wait states. illegal_op and mem_err are mutually exclusive and sticky until reset.
//  - rst_n asserted mid-instruction: immediate abort, no partial strobe after deassertion. Resumes in FETCH.
// CONFIGURATION
//  MIPS_PERF_CNT_EN defined:
//    cycle_cnt increments every cycle after reset, including HALT; wraps at 2^CNT_W.
//    instr_cnt increments on each instr_done; wraps at 2^CNT_W.
//  MIPS_PERF_CNT_EN undefined: cycle_cnt and instr_cnt tied to 0; no counter flops.
// TESTING
//  1. add (opcode 0), mem_ready=1 -> states 0,1,6,7,0; instr_done high in cycle 4 only; reg_write+reg_dst in ALUWB.
//  2. lw with mem_ready=0 for 3 cycles in MEMRD -> stays in state 3 for 4 cycles; CPI=8; mem_to_reg+reg_write in MEMWB.
//  3. opcode 111111 -> DECODE goes to HALT; illegal_op=1, halted=1, all strobes 0 for 20 further cycles; rst_n low clears all.
//  4. MEM_TIMEOUT=4, sw with mem_ready held 0 -> HALT after 4 wait cycles, mem_err=1, mem_write drops.
//     Repeat with ready on cycle 4 -> no error.
//  5. beq then j -> 3 cycles each; pc_write_cond/pc_source=01, then pc_write/pc_source=10.
//     With MIPS_PERF_CNT_EN: instr_cnt=2, cycle_cnt=6.
//  6. rst_n pulsed low in MEMADR of sw -> outputs 0 immediately; after release, FETCH with mem_read=1 and no mem_write ever seen.

Source files
------------

// File: rtl/mips_multicycle_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mips_multicycle_controller_if                                     |
// | Brief  : Control/status bundle between the multi-cycle controller and the  |
// |          datapath.                                                         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface mips_multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             ir_write;
    logic [1:0]       pc_source;
    logic [1:0]       alu_op;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             reg_write;
    logic             reg_dst;
    logic             instr_done;
    logic             halted;
    logic             illegal_op;
    logic             mem_err;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
               ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write,
               reg_dst, instr_done, halted, illegal_op, mem_err, state_dbg,
               cycle_cnt, instr_cnt
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
               ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write,
               reg_dst, instr_done, halted, illegal_op, mem_err, state_dbg,
               cycle_cnt, instr_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mips_multicycle_controller                                        |
// | Brief  : Multi-cycle MIPS control FSM with memory-ready stall and timeout. |
// |          Define MIPS_PERF_CNT_EN to build the cycle/instruction counters.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mips_multicycle_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    mips_multicycle_controller_if.master bus
);
    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam int         c_WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    state_t              r_state, w_next;
    logic [c_WAIT_W-1:0] r_wait_cnt, w_wait_inc;
    logic                r_illegal, r_mem_err;
    logic                w_wait_state, w_timeout, w_illegal;
    logic                w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
    logic                w_mem_to_reg, w_ir_write, w_alu_src_a, w_reg_write, w_reg_dst;
    logic                w_instr_done, w_halted;
    logic [1:0]          w_pc_source, w_alu_op, w_alu_src_b;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_wait_inc   = r_wait_cnt + c_WAIT_W'(1);
    // Ready arriving in the final allowed wait cycle still completes the access.
    assign w_timeout    = (MEM_TIMEOUT != 0) && w_wait_state && !bus.mem_ready &&
                          (w_wait_inc == c_WAIT_W'(MEM_TIMEOUT));

    always_comb begin
        w_next          = r_state;
        w_illegal       = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_source     = 2'b00;
        w_alu_op        = 2'b00;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_instr_done    = 1'b0;
        w_halted        = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (bus.opcode)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_R:           w_next = S_EXEC;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    default: begin
                        w_next    = S_HALT;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (bus.opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_instr_done    = 1'b1;
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_source  = 2'b10;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_HALT:  w_halted = 1'b1;
            default: w_next   = S_FETCH;
        endcase
        if (w_timeout) w_next = S_HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_wait_state && !bus.mem_ready)
                r_wait_cnt <= w_wait_inc;
            if (w_illegal) r_illegal <= 1'b1;
            if (w_timeout) r_mem_err <= 1'b1;
        end
    end

    // Reset forces every strobe low combinationally, even though FETCH is the reset state.
    assign bus.pc_write      = rst_n & w_pc_write;
    assign bus.pc_write_cond = rst_n & w_pc_write_cond;
    assign bus.i_or_d        = rst_n & w_i_or_d;
    assign bus.mem_read      = rst_n & w_mem_read;
    assign bus.mem_write     = rst_n & w_mem_write;
    assign bus.mem_to_reg    = rst_n & w_mem_to_reg;
    assign bus.ir_write      = rst_n & w_ir_write;
    assign bus.pc_source     = {2{rst_n}} & w_pc_source;
    assign bus.alu_op        = {2{rst_n}} & w_alu_op;
    assign bus.alu_src_a     = rst_n & w_alu_src_a;
    assign bus.alu_src_b     = {2{rst_n}} & w_alu_src_b;
    assign bus.reg_write     = rst_n & w_reg_write;
    assign bus.reg_dst       = rst_n & w_reg_dst;
    assign bus.instr_done    = rst_n & w_instr_done;
    assign bus.halted        = rst_n & w_halted;
    assign bus.illegal_op    = r_illegal;
    assign bus.mem_err       = r_mem_err;
    assign bus.state_dbg     = r_state;

`ifdef MIPS_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt, r_instr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_instr_done) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
    assign bus.instr_cnt = r_instr_cnt;
`else
    assign bus.cycle_cnt = '0;
    assign bus.instr_cnt = '0;
`endif
endmodule
`default_nettype wire
